// File: rtl/ps2_key_encoder_if.sv
// Signal bundle between the PS/2 front end and its consumer.
// The raw keyboard lines come in; the decoded key word and byte status go out.
interface ps2_key_encoder_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [10:0] ps2_key;
  logic        byte_stb;
  logic [7:0]  byte_data;
  logic        err_parity;
  logic        err_frame;

  modport master (
    input  ps2_clk, ps2_data,
    output ps2_key, byte_stb, byte_data, err_parity, err_frame
  );

  modport slave (
    output ps2_clk, ps2_data,
    input  ps2_key, byte_stb, byte_data, err_parity, err_frame
  );
endinterface

// File: rtl/ps2_key_encoder.sv
// Host-side PS/2 keyboard receiver: conditions the raw lines, deserialises 11-bit
// frames and turns scancode-set-2 sequences into the toggle-event ps2_key word.
module ps2_key_encoder #(
  parameter int FILT_LEN    = 8,
  parameter int TIMEOUT_CYC = 24000
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  ps2_key_encoder_if.master bus
);

  localparam int FILT_W = $clog2(FILT_LEN + 1);
  localparam int TOUT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILT_LEN - 1);
  localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(TIMEOUT_CYC - 1);
  localparam logic [3:0]        STOP_BIT  = 4'd9;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } rx_state_t;

  // Input conditioning
  logic              clk_meta, clk_sync;
  logic              data_meta, data_sync;
  logic              clk_filt, clk_filt_d;
  logic [FILT_W-1:0] filt_cnt;
  logic              fall;

  // Receiver
  rx_state_t         state, state_next;
  logic [3:0]        bit_cnt;
  logic [8:0]        shift_reg;
  logic [TOUT_W-1:0] tout_cnt;
  logic              frame_end;
  logic              tout_hit;
  logic              parity_ok;
  logic              stop_ok;
  logic              frame_good;

  // Status and decoder
  logic              byte_stb_q;
  logic [7:0]        byte_data_q;
  logic              err_parity_q;
  logic              err_frame_q;
  logic [10:0]       key_q;
  logic              ext_q;
  logic              rel_q;
  logic [2:0]        skip_q;

  // NOTE: both lines are asynchronous to clk_sys; nothing may look at them
  // before they have passed through two flops.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= bus.ps2_clk;
      clk_sync  <= clk_meta;
      data_meta <= bus.ps2_data;
      data_sync <= data_meta;
    end
  end

  // The filtered clock follows the synced one only after FILT_LEN agreeing samples,
  // so short glitches on a long keyboard cable never produce a sample edge.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
      filt_cnt   <= '0;
    end else begin
      clk_filt_d <= clk_filt;
      if (clk_sync == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        clk_filt <= clk_sync;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign fall = clk_filt_d & ~clk_filt;

  // NOTE: sequential state is updated only with non-blocking assignments so every
  // flop sees the pre-edge value of every other flop.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every signal written here gets a default first, otherwise paths that
  // skip an assignment would infer a latch.
  always_comb begin
    state_next = state;
    frame_end  = 1'b0;
    tout_hit   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fall && !data_sync) begin
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (fall) begin
          if (bit_cnt == STOP_BIT) begin
            state_next = ST_IDLE;
            frame_end  = 1'b1;
          end
        end else if (tout_cnt == TOUT_LAST) begin
          state_next = ST_IDLE;
          tout_hit   = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Data bits 0..7 then parity are shifted in from the top, so after nine edges
  // shift_reg holds {parity, data[7:0]}; the stop bit is judged live from data_sync.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
      tout_cnt  <= '0;
    end else begin
      if (state == ST_IDLE || fall) begin
        tout_cnt <= '0;
      end else begin
        tout_cnt <= tout_cnt + 1'b1;
      end

      if (state == ST_IDLE) begin
        bit_cnt <= '0;
      end else if (fall && bit_cnt != STOP_BIT) begin
        shift_reg <= {data_sync, shift_reg[8:1]};
        bit_cnt   <= bit_cnt + 1'b1;
      end
    end
  end

  // Odd parity: data plus parity bit must carry an odd number of ones.
  assign parity_ok  = ^shift_reg;
  assign stop_ok    = data_sync;
  assign frame_good = frame_end & parity_ok & stop_ok;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      byte_stb_q   <= 1'b0;
      byte_data_q  <= '0;
      err_parity_q <= 1'b0;
      err_frame_q  <= 1'b0;
    end else begin
      byte_stb_q   <= frame_good;
      err_parity_q <= frame_end & ~parity_ok;
      err_frame_q  <= tout_hit | (frame_end & parity_ok & ~stop_ok);
      if (frame_good) begin
        byte_data_q <= shift_reg[7:0];
      end
    end
  end

  // Scancode decoder: runs one cycle behind byte_stb on the already-latched byte.
  // An E1 swallows the remaining seven bytes of the Pause sequence.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      key_q  <= '0;
      ext_q  <= 1'b0;
      rel_q  <= 1'b0;
      skip_q <= '0;
    end else if (err_parity_q || err_frame_q) begin
      ext_q <= 1'b0;
      rel_q <= 1'b0;
    end else if (byte_stb_q) begin
      if (skip_q != 3'd0) begin
        skip_q <= skip_q - 1'b1;
      end else begin
        case (byte_data_q)
          8'hE1: skip_q <= 3'd7;
          8'hE0: ext_q  <= 1'b1;
          8'hF0: rel_q  <= 1'b1;
          8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: begin
            ext_q <= 1'b0;
            rel_q <= 1'b0;
          end
          default: begin
            key_q <= {~key_q[10], ~rel_q, ext_q, byte_data_q};
            ext_q <= 1'b0;
            rel_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.ps2_key    = key_q;
  assign bus.byte_stb   = byte_stb_q;
  assign bus.byte_data  = byte_data_q;
  assign bus.err_parity = err_parity_q;
  assign bus.err_frame  = err_frame_q;

endmodule
